// File: rtl/uart_rx_ctrl_module_pkg.sv
// Shared UART controller definitions: frame state encodings and default frame width.
// Used by both the RX controller and the future TX controller.
package uart_rx_ctrl_module_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_ctrl_module_sync_edge.sv
// RX line conditioning: SYNC_STAGES-deep synchroniser (reset to idle-high)
// followed by a history flop for start-bit falling-edge detection.
module rx_sync_edge_module #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic RX_Pin_In,
    output logic Rx_Sync,
    output logic H2L_Sig
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RX_Pin_In};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign Rx_Sync = r_sync[SYNC_STAGES-1];
    assign H2L_Sig = r_hist & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl_module.sv
// UART receive sequencer: runs the external bit-rate counter and assembles one frame
// per start edge. Define RX_PARITY_EN for a parity bit, Parity_Err and PARITY_ODD.
module uart_rx_ctrl_module
    import uart_rx_ctrl_module_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
`ifdef RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 Rx_En,
    input  logic                 RX_Pin_In,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Done_Sig,
    output logic                 Frame_Err
`ifdef RX_PARITY_EN
    ,
    output logic                 Parity_Err
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic w_rx_sync;
    logic w_h2l;

    uart_state_e          r_state;
    logic                 r_count_sig;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_done;
    logic                 r_ferr;
`ifdef RX_PARITY_EN
    logic                 r_par_acc;
    logic                 r_par_bad;
    logic                 r_perr;
`endif

    rx_sync_edge_module #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .RX_Pin_In (RX_Pin_In),
        .Rx_Sync   (w_rx_sync),
        .H2L_Sig   (w_h2l)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= ST_IDLE;
            r_count_sig <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rx_data   <= '0;
            r_done      <= 1'b0;
            r_ferr      <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_acc   <= 1'b0;
            r_par_bad   <= 1'b0;
            r_perr      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
`ifdef RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            if (!Rx_En) begin
                // Disable aborts any frame silently; Rx_Data keeps the last good byte.
                r_state     <= ST_IDLE;
                r_count_sig <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_h2l) begin
                            r_count_sig <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (BPS_CLK) begin
                            if (!w_rx_sync) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
`ifdef RX_PARITY_EN
                                r_par_acc <= PARITY_ODD;
`endif
                            end else begin
                                r_state     <= ST_IDLE;
                                r_count_sig <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (BPS_CLK) begin
                            r_shift   <= {w_rx_sync, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef RX_PARITY_EN
                            r_par_acc <= r_par_acc ^ w_rx_sync;
                            if (r_bit_cnt == LAST_BIT) r_state <= ST_PARITY;
`else
                            if (r_bit_cnt == LAST_BIT) r_state <= ST_STOP;
`endif
                        end
                    end
`ifdef RX_PARITY_EN
                    ST_PARITY: begin
                        if (BPS_CLK) begin
                            // r_par_acc holds the parity bit the sender should have sent.
                            r_par_bad <= w_rx_sync ^ r_par_acc;
                            r_state   <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (BPS_CLK) begin
                            r_state     <= ST_IDLE;
                            r_count_sig <= 1'b0;
                            if (!w_rx_sync) begin
                                r_ferr <= 1'b1;
`ifdef RX_PARITY_EN
                            end else if (r_par_bad) begin
                                r_perr <= 1'b1;
`endif
                            end else begin
                                r_rx_data <= r_shift;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_count_sig <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Count_Sig   = r_count_sig;
    assign Rx_Data     = r_rx_data;
    assign Rx_Done_Sig = r_done;
    assign Frame_Err   = r_ferr;
`ifdef RX_PARITY_EN
    assign Parity_Err  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl_module.sv
// Self-checking bench for uart_rx_ctrl_module with a time-scaled bit-rate counter model
// (BIT clocks per bit, strobe at mid-bit). Works with or without RX_PARITY_EN.
module tb_uart_rx_ctrl_module;

    localparam int BIT  = 32;
    localparam int HALF = 16;
`ifdef RX_PARITY_EN
    localparam int LAT  = 10 * BIT + HALF + 4;
`else
    localparam int LAT  = 9 * BIT + HALF + 4;
`endif

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       Rx_En = 1'b0;
    logic       RX_Pin_In = 1'b1;
    logic       BPS_CLK;
    logic       Count_Sig;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
    logic       Frame_Err;
`ifdef RX_PARITY_EN
    logic       Parity_Err;
`endif

    logic bps_force = 1'b0;
    int   cnt = 0;
    int   cyc = 0;

    int n_pass = 0;
    int n_total = 0;

    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         cs_high = 0;
    int         done_cyc = 0;
    int         dbl_pulse = 0;
    int         cs_with_done = 0;
    int         excl_bad = 0;
    logic       prev_done = 1'b0;
    logic [7:0] done_log [16];

    uart_rx_ctrl_module u_dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Rx_En       (Rx_En),
        .RX_Pin_In   (RX_Pin_In),
        .BPS_CLK     (BPS_CLK),
        .Count_Sig   (Count_Sig),
        .Rx_Data     (Rx_Data),
        .Rx_Done_Sig (Rx_Done_Sig),
`ifdef RX_PARITY_EN
        .Frame_Err   (Frame_Err),
        .Parity_Err  (Parity_Err)
`else
        .Frame_Err   (Frame_Err)
`endif
    );

    always #5 CLK = ~CLK;

    // Bit-rate counter model: cleared while Count_Sig is low, mid-bit strobe.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!Count_Sig)        cnt <= 0;
        else if (cnt == BIT-1) cnt <= 0;
        else                   cnt <= cnt + 1;
    end
    assign BPS_CLK = bps_force | (Count_Sig && cnt == HALF);

    always @(negedge CLK) begin
        if (Rx_Done_Sig) begin
            done_log[done_cnt % 16] <= Rx_Data;
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (prev_done) dbl_pulse <= dbl_pulse + 1;
            if (Count_Sig) cs_with_done <= cs_with_done + 1;
            if (Frame_Err) excl_bad <= excl_bad + 1;
        end
        if (Frame_Err) ferr_cnt <= ferr_cnt + 1;
`ifdef RX_PARITY_EN
        if (Parity_Err) perr_cnt <= perr_cnt + 1;
`endif
        if (Count_Sig) cs_high <= cs_high + 1;
        prev_done <= Rx_Done_Sig;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic v, input int n);
        RX_Pin_In = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int start_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        start_cyc = cyc;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef RX_PARITY_EN
        drive_bit(^d, BIT);
`endif
        drive_bit(stop, stop_len);
        RX_Pin_In = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int d0, f0, p0, c0, len;

        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_rx: 8'h55};
        vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_done: 0, exp_ferr: 1, exp_rx: 8'h55};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_rx: 8'h81};
        vecs[3] = '{data: 8'hC6, stop: 1'b0, exp_done: 0, exp_ferr: 1, exp_rx: 8'h81};

        // Reset state
        repeat (4) @(posedge CLK);
        #1;
        check("rst_count_sig", 32'(Count_Sig), 32'd0);
        check("rst_rx_data", 32'(Rx_Data), 32'd0);
        check("rst_done", 32'(Rx_Done_Sig), 32'd0);
        check("rst_ferr", 32'(Frame_Err), 32'd0);
        RST_n = 1'b1;
        Rx_En = 1'b1;
        drive_bit(1'b1, BIT);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, BIT);
            drive_bit(1'b1, 2 * BIT);
            check($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_rx_data", v), 32'(Rx_Data), 32'(vecs[v].exp_rx));
            if (vecs[v].exp_done == 1)
                check($sformatf("vec%0d_latency", v), 32'(done_cyc - start_cyc), 32'(LAT));
        end

        // Short start glitch: counter runs to the start-bit sample, then aborts.
        d0 = done_cnt;
        f0 = ferr_cnt;
        c0 = cs_high;
        drive_bit(1'b0, 6);
        drive_bit(1'b1, 3 * BIT);
        len = cs_high - c0;
        check("glitch_cs_len", 32'(len >= HALF && len <= HALF + 2), 32'd1);
        check("glitch_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_rx_data", 32'(Rx_Data), 32'h81);

        // BPS_CLK in IDLE has no effect
        d0 = done_cnt;
        bps_force = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        bps_force = 1'b0;
        drive_bit(1'b1, 4);
        check("idle_bps_cs", 32'(Count_Sig), 32'd0);
        check("idle_bps_done", 32'(done_cnt - d0), 32'd0);

        // Back-to-back: next start edge shortly after the stop-bit midpoint
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, HALF + 10);
        send_frame(8'hFF, 1'b1, BIT);
        drive_bit(1'b1, 2 * BIT);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_first", 32'(done_log[d0 % 16]), 32'h00);
        check("b2b_second", 32'(done_log[(d0 + 1) % 16]), 32'hFF);
        check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Asynchronous reset during data bit 4
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
        drive_bit(1'b0, 10);
        check("pre_rst_cs", 32'(Count_Sig), 32'd1);
        #2;
        RST_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(Count_Sig), 32'd0);
        check("mid_rst_rx_data", 32'(Rx_Data), 32'd0);
        check("mid_rst_done", 32'(Rx_Done_Sig), 32'd0);
        check("mid_rst_ferr", 32'(Frame_Err), 32'd0);
        @(posedge CLK);
        #1;
        d0 = done_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b1, 4 * BIT);
        RST_n = 1'b1;
        drive_bit(1'b1, BIT);
        check("post_rst_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0), 32'd0);
        send_frame(8'h3C, 1'b1, BIT);
        drive_bit(1'b1, 2 * BIT);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_rx_data", 32'(Rx_Data), 32'h3C);

        // Rx_En dropped during data bit 2
        d0 = done_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, 10);
        Rx_En = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("en_drop_cs", 32'(Count_Sig), 32'd0);
        @(posedge CLK);
        #1;
        drive_bit(1'b1, 8 * BIT);
        Rx_En = 1'b1;
        drive_bit(1'b1, BIT);
        check("en_drop_done", 32'(done_cnt - d0), 32'd0);
        check("en_drop_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("en_drop_rx_data", 32'(Rx_Data), 32'h3C);

`ifdef RX_PARITY_EN
        // 0x07 with parity bit 0 under even parity
        d0 = done_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(i < 3, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, 3 * BIT);
        check("par_perr", 32'(perr_cnt - p0), 32'd1);
        check("par_done", 32'(done_cnt - d0), 32'd0);
        check("par_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("par_rx_data", 32'(Rx_Data), 32'h3C);
`else
        p0 = perr_cnt;
        check("no_parity_pulses", 32'(p0), 32'd0);
`endif

        check("single_cycle_done", 32'(dbl_pulse), 32'd0);
        check("cs_low_with_done", 32'(cs_with_done), 32'd0);
        check("done_ferr_exclusive", 32'(excl_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
